// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - single-precision field widths, operand struct and align state encoding
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = 24;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        SHIFT,
        DONE
    } align_state_t;
endpackage

// File: rtl/fp_field_decode.sv
// rtl/fp_field_decode.sv - effective exponent and hidden bit of one single-precision operand
module fp_field_decode
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0] exp_raw,
    output logic [EXP_W-1:0] eff_exp,
    output logic             hidden
);
    // Denormals and zero behave as exponent 1 with no hidden bit.
    assign hidden  = |exp_raw;
    assign eff_exp = hidden ? exp_raw : EXP_W'(1);
endmodule

// File: rtl/fp_align_ctrl.sv
// rtl/fp_align_ctrl.sv - FP adder operand alignment sequencer; FP_ALIGN_STICKY_EN adds the sticky bit
module fp_align_ctrl
    import fp_pkg::*;
#(
    parameter int MAX_SHIFT = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic [22:0] shf_data_o,
    output logic [4:0]  shf_amt_o,
    input  logic [22:0] shf_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  exp_o,
    output logic [23:0] mant_big_o,
    output logic [23:0] mant_small_o,
    output logic        sign_big_o,
    output logic        sign_small_o,
    output logic        swap_o,
    output logic        sticky_o
);
    localparam logic [EXP_W-1:0] MAX_SHIFT_D = EXP_W'(MAX_SHIFT);

    align_state_t state, state_next;
    fp32_t op_a, op_b;
    logic [EXP_W-1:0] eff_a, eff_b, eff_big, diff;
    logic hid_a, hid_b, hid_big, hid_small, swap;
    logic sign_big, sign_small;
    logic [FRAC_W-1:0] frac_big, frac_small;
    logic [SIG_W-1:0] sig_small, mant_small_next;
    logic [4:0] hid_pos;

    fp_field_decode u_dec_a (.exp_raw(op_a.exp), .eff_exp(eff_a), .hidden(hid_a));
    fp_field_decode u_dec_b (.exp_raw(op_b.exp), .eff_exp(eff_b), .hidden(hid_b));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid_i) state_next = CMP;
            CMP:     state_next = SHIFT;
            SHIFT:   state_next = DONE;
            DONE:    if (out_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    always_comb begin
        eff_big    = swap ? eff_b : eff_a;
        hid_big    = swap ? hid_b : hid_a;
        hid_small  = swap ? hid_a : hid_b;
        frac_big   = swap ? op_b.frac : op_a.frac;
        frac_small = swap ? op_a.frac : op_b.frac;
        sign_big   = swap ? op_b.sign : op_a.sign;
        sign_small = swap ? op_a.sign : op_b.sign;
        sig_small  = {hid_small, frac_small};
    end

    assign shf_data_o = (state == SHIFT) ? frac_small : '0;
    assign shf_amt_o  = (state != SHIFT) ? 5'd0 :
                        (diff > 8'd31)   ? 5'd31 : diff[4:0];

    // The shifter only sees the fraction, so the hidden bit is re-inserted at bit 23-d.
    assign hid_pos = 5'(FRAC_W) - diff[4:0];

    always_comb begin
        if (diff == '0)
            mant_small_next = sig_small;
        else if (diff >= MAX_SHIFT_D)
            mant_small_next = '0;
        else
            mant_small_next = {1'b0, shf_data_i} | (SIG_W'(hid_small) << hid_pos);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a         <= '0;
            op_b         <= '0;
            swap         <= 1'b0;
            diff         <= '0;
            exp_o        <= '0;
            mant_big_o   <= '0;
            mant_small_o <= '0;
            sign_big_o   <= 1'b0;
            sign_small_o <= 1'b0;
            swap_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    op_a <= op_a_i;
                    op_b <= op_b_i;
                end
                CMP: begin
                    swap <= (eff_b > eff_a);
                    diff <= (eff_b > eff_a) ? (eff_b - eff_a) : (eff_a - eff_b);
                end
                SHIFT: begin
                    exp_o        <= eff_big;
                    mant_big_o   <= {hid_big, frac_big};
                    mant_small_o <= mant_small_next;
                    sign_big_o   <= sign_big;
                    sign_small_o <= sign_small;
                    swap_o       <= swap;
                end
                default: ;
            endcase
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    logic [SIG_W-1:0] lost_mask;
    logic             sticky_q;

    always_comb begin
        if (diff >= EXP_W'(SIG_W))
            lost_mask = '1;
        else
            lost_mask = (SIG_W'(1) << diff[4:0]) - SIG_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            sticky_q <= 1'b0;
        else if (state == SHIFT)
            sticky_q <= |(sig_small & lost_mask);
    end

    assign sticky_o = sticky_q;
`else
    assign sticky_o = 1'b0;
`endif
endmodule

// File: tb/tb_fp_align_ctrl.sv
// tb/tb_fp_align_ctrl.sv - randomized self-checking bench for fp_align_ctrl against an arithmetic model
module tb_fp_align_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] op_a_i, op_b_i;
    logic [22:0] shf_data_o;
    logic [4:0]  shf_amt_o;
    logic [22:0] shf_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  exp_o;
    logic [23:0] mant_big_o, mant_small_o;
    logic        sign_big_o, sign_small_o, swap_o, sticky_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Behavioural external barrel shifter.
    assign shf_data_i = shf_data_o >> shf_amt_o;

    fp_align_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i),
        .shf_data_o(shf_data_o), .shf_amt_o(shf_amt_o), .shf_data_i(shf_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .exp_o(exp_o), .mant_big_o(mant_big_o), .mant_small_o(mant_small_o),
        .sign_big_o(sign_big_o), .sign_small_o(sign_small_o),
        .swap_o(swap_o), .sticky_o(sticky_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Expected results
    logic        m_swap, m_sb, m_ss, m_sticky;
    logic [7:0]  m_exp;
    logic [23:0] m_big, m_small;
    logic [22:0] m_sfrac;
    int          m_d;

    task automatic model(input logic [31:0] a, input logic [31:0] b);
        int unsigned ea, eb, sa, sb, sig_s, lost;
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        sa = ((a[30:23] != 0) ? 32'h80_0000 : 0) + a[22:0];
        sb = ((b[30:23] != 0) ? 32'h80_0000 : 0) + b[22:0];
        m_swap  = (eb > ea);
        m_d     = m_swap ? int'(eb - ea) : int'(ea - eb);
        m_exp   = 8'(m_swap ? eb : ea);
        m_big   = 24'(m_swap ? sb : sa);
        sig_s   = m_swap ? sa : sb;
        m_sb    = m_swap ? b[31] : a[31];
        m_ss    = m_swap ? a[31] : b[31];
        m_sfrac = 23'(sig_s % 32'h80_0000);
        if (m_d >= 24) begin
            m_small = 24'd0;
            lost    = sig_s;
        end else begin
            m_small = 24'(sig_s / (32'd1 << m_d));
            lost    = sig_s % (32'd1 << m_d);
        end
`ifdef FP_ALIGN_STICKY_EN
        m_sticky = (lost != 0);
`else
        m_sticky = 1'b0;
`endif
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_swap"},    32'(swap_o),       32'(m_swap));
        check({tag, "_exp"},     32'(exp_o),        32'(m_exp));
        check({tag, "_big"},     32'(mant_big_o),   32'(m_big));
        check({tag, "_small"},   32'(mant_small_o), 32'(m_small));
        check({tag, "_sgn_big"}, 32'(sign_big_o),   32'(m_sb));
        check({tag, "_sgn_sml"}, 32'(sign_small_o), 32'(m_ss));
        check({tag, "_sticky"},  32'(sticky_o),     32'(m_sticky));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        int n = 0;
        while (!in_ready_o && n < 10) begin
            tick();
            n++;
        end
        check("idle_ready", 32'(in_ready_o), 32'd1);
        model(a, b);
        op_a_i = a;
        op_b_i = b;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("cmp_ready", 32'(in_ready_o), 32'd0);
        check("cmp_valid", 32'(out_valid_o), 32'd0);
        tick();
        check("shf_amt",   32'(shf_amt_o),  32'((m_d > 31) ? 31 : m_d));
        check("shf_data",  32'(shf_data_o), 32'(m_sfrac));
        check("shf_valid", 32'(out_valid_o), 32'd0);
        tick();
        check("latency3",  32'(out_valid_o), 32'd1);
        check("amt_quiet", 32'(shf_amt_o), 32'd0);
        check_outputs("res");
        for (int i = 0; i < hold; i++) begin
            in_valid_i = 1'b1;
            op_a_i = $urandom;
            op_b_i = $urandom;
            tick();
            check("bp_ready", 32'(in_ready_o), 32'd0);
            check("bp_valid", 32'(out_valid_o), 32'd1);
            check_outputs("bp");
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("rel_valid", 32'(out_valid_o), 32'd0);
        check("rel_ready", 32'(in_ready_o), 32'd1);
    endtask

    task automatic reset_mid_op(input logic [31:0] a, input logic [31:0] b);
        int seen = 0;
        op_a_i = a;
        op_b_i = b;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        check("rst_in_shift", 32'(shf_amt_o != 0), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_ready", 32'(in_ready_o), 32'd1);
        check("rst_exp",   32'(exp_o), 32'd0);
        check("rst_big",   32'(mant_big_o), 32'd0);
        check("rst_small", 32'(mant_small_o), 32'd0);
        check("rst_swap",  32'(swap_o), 32'd0);
        check("rst_amt",   32'(shf_amt_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid_o) seen++;
        end
        check("rst_no_result", 32'(seen), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        op_a_i      = '0;
        op_b_i      = '0;
        tick();
        tick();
        check("reset_ready", 32'(in_ready_o), 32'd1);
        check("reset_valid", 32'(out_valid_o), 32'd0);
        check("reset_exp",   32'(exp_o), 32'd0);
        check("reset_small", 32'(mant_small_o), 32'd0);
        check("reset_data",  32'(shf_data_o), 32'd0);
        check("reset_amt",   32'(shf_amt_o), 32'd0);
        check("reset_stk",   32'(sticky_o), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(32'h3F80_0000, 32'h4000_0000, 0);
        check("tp1_small", 32'(mant_small_o), 32'h40_0000);
        run_op(32'h4120_0000, 32'h3F80_0007, 0);
        check("tp2_small", 32'(mant_small_o), 32'h10_0000);
        run_op(32'h4B80_0000, 32'h3F80_0001, 0);
        run_op(32'h0000_0001, 32'h0080_0000, 0);
        check("tp4_big", 32'(mant_big_o), 32'h00_0001);
        run_op(32'h3F80_0000, 32'h4000_0000, 5);
        reset_mid_op(32'h4120_0000, 32'h3F80_0007);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] a, b;
            int ea, eb;
            ea = int'($urandom_range(0, 255));
            eb = ea + int'($urandom_range(0, 60)) - 30;
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            a = $urandom;
            b = $urandom;
            if (k % 4 != 0) begin
                a[30:23] = 8'(ea);
                b[30:23] = 8'(eb);
            end
            run_op(a, b, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/fp_align_ctrl.md
Name: fp_align_ctrl

Overview:
Operand-alignment sequencer for the FP adder front end. Accepts two IEEE-754 single-precision operands over a valid/ready handshake and compares exponents. Swaps the operands so the larger-exponent one is "big", then drives the external 23-bit right barrel shifter to align the smaller fraction. Re-inserts the hidden bit and presents aligned 24-bit significands plus the common exponent to the add/normalise stage.

Parameters:
- MAX_SHIFT, 24, difference at or above which the small significand is fully shifted out (forced to zero).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  controller can accept operands
- op_a_i  in  32  operand A
- op_b_i  in  32  operand B
- shf_data_o  out  23  fraction to external barrel shifter
- shf_amt_o  out  5  shift amount to external barrel shifter
- shf_data_i  in  23  shifter result (combinational, same cycle)
- out_valid_o  out  1  aligned result valid
- out_ready_i  in  1  downstream accepts result
- exp_o  out  8  common (larger effective) exponent
- mant_big_o  out  24  {hidden, frac} of big operand
- mant_small_o  out  24  aligned significand of small operand
- sign_big_o  out  1  sign of big operand
- sign_small_o  out  1  sign of small operand
- swap_o  out  1  1 = B is big
- sticky_o  out  1  OR of bits shifted out (only with FP_ALIGN_STICKY_EN)

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, in_ready_o=1, out_valid_o=0, all data outputs 0, shf_data_o=0, shf_amt_o=0. Reset mid-operation abandons the operation with no output.
- Field decode: effective exponent = raw exponent, or 1 if raw exponent is 0; hidden bit = (raw exponent != 0). No special handling of Inf/NaN; they align as ordinary numbers.
- FSM IDLE -> CMP -> SHIFT -> DONE -> IDLE.
  - IDLE: in_ready_o=1. On in_valid_i & in_ready_o: register both operands and go to CMP.
  - CMP: if effB > effA, swap=1; otherwise swap=0 (equal exponents keep A big, no mantissa compare). Register d = exp_big - exp_small (8-bit, 0..254). Go to SHIFT.
  - SHIFT: drive shf_data_o = small fraction and shf_amt_o = min(d,31); all other cycles drive 0.
    - Sample shf_data_i the same cycle.
    - d=0: mant_small = {hidden, frac}.
    - 1<=d<=23: mant_small = {0, shf_data_i} OR (hidden << (23-d)).
    - d>=MAX_SHIFT: mant_small = 0.
    - Register outputs and set out_valid_o. Go to DONE.
  - DONE: hold all outputs stable while out_valid_o & !out_ready_i. On out_ready_i: clear out_valid_o and go to IDLE.
- Latency: acceptance edge to out_valid_o is 3 cycles.
- Throughput: minimum 4 cycles per operation (single outstanding operation). in_ready_o=0 outside IDLE; in_valid_i is ignored there.

Optional Feature:
- FP_ALIGN_STICKY_EN
  - Defined: sticky_o = OR of all small-significand bits (hidden included) shifted out, computed in SHIFT and registered with the other outputs. d=0 gives 0; d>=24 gives the OR of the whole significand.
  - Undefined: sticky_o is tied to 0 and no mask logic is built.

Decomposition:
- Package fp_pkg: SP field widths (EXP_W=8, FRAC_W=23, SIG_W=24), typedef fp32_t (sign/exp/frac struct), align state enum (IDLE, CMP, SHIFT, DONE).
- One sub-module fp_field_decode (effective exponent + hidden bit), instantiated twice.
- The barrel shifter stays external, connected through the shf_* ports.

Test Plan:
- A=0x3F800000, B=0x40000000: swap_o=1, exp_o=0x80, mant_big_o=0x800000, mant_small_o=0x400000, sticky_o=0; out_valid_o exactly 3 cycles after acceptance.
- A=0x41200000, B=0x3F800007: swap_o=0, exp_o=0x82, d=3, shf_amt_o=3 in SHIFT, mant_big_o=0xA00000, mant_small_o=0x100000, sticky_o=1 (EN) / 0 (no EN).
- A=0x4B800000, B=0x3F800001: d=24, mant_small_o=0x000000, sticky_o=1 (EN); shf_amt_o=24.
- A=0x00000001, B=0x00800000: both effective exponents 1, swap_o=0, exp_o=0x01, mant_big_o=0x000001, mant_small_o=0x800000.
- Backpressure, using the first vector: out_ready_i low for 5 cycles -> outputs stable, in_ready_o=0, a second in_valid_i is ignored. Raise out_ready_i -> in_ready_o=1 the next cycle.
- Reset mid-op: assert rst_n=0 in the SHIFT cycle -> next cycle out_valid_o=0, in_ready_o=1, outputs 0, and no result ever appears.
